tristate_bus_arbiter: RTL and testbench
=======================================

# tristate_bus_arbiter

Round-robin arbiter and sequencer for a shared WIDTH-bit tristate bus with NREQ potential drivers. It grants bus ownership to at most one requester at a time and produces the per-line output enables and data that feed the `assign ts_i = oe ? d : 1'bz` drivers. It inserts a mandatory all-released turnaround gap between owners, so two drivers can never enable in the same or adjacent cycles. It sits between requesting agents and the tristate pad/model layer.

## Interface
- NREQ, 4, number of requesters (≥2)
- WIDTH, 4, bus lines (one tristate per line)
- MAX_HOLD, 8, max consecutive DRIVE cycles per grant (≥1)
- TURNAROUND, 1, released-bus cycles between owners (≥1)

- clk  input  1  sole clock, all state on posedge
- reset  input  1  synchronous, active-high
- req  input  NREQ  req[i]=1: requester i wants the bus; level, held while it wants to drive
- wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- grant  output  NREQ  one-hot or zero; registered
- bus_oe  output  WIDTH  per-line drive enable; all bits equal; registered
- bus_d  output  WIDTH  data for the lines; wdata slice of granted requester, 0 when no grant
- busy  output  1  high in DRIVE or TURN

## Operation
- States: IDLE, DRIVE, TURN. Encoding is free.
- Reset: state=IDLE, grant=0, bus_oe=0, busy=0, hold counter=0, turn counter=0, rr pointer=0, so requester 0 has highest priority.
- IDLE: grant=0, bus_oe=0. If any req, the winner is the first set req at or after the pointer, searching upward with wrap at NREQ-1→0. Next state is DRIVE with grant=onehot(winner), bus_oe=all ones, and hold=1.
- DRIVE: grant and bus_oe hold. Each cycle:
  - If req[g]=0, or hold==MAX_HOLD with req[g] still 1, go to TURN. grant=0, bus_oe=0, turn=1, pointer=(g+1) mod NREQ.
  - Otherwise hold increments.
- TURN: grant=0, bus_oe=0, busy=1. When turn==TURNAROUND, go to IDLE. Otherwise turn increments. Requests are ignored in TURN.
- bus_d is combinational: an AND-OR mux of wdata by registered grant. It must be 0 whenever grant==0.
- A preempted requester that keeps req high re-competes in IDLE. It gets the bus again only after every other active requester has had one turn.
- req changes of non-granted requesters during DRIVE have no effect.
- Invariants:
  - popcount(grant)≤1.
  - bus_oe==all-ones iff grant!=0.
  - Between any grant falling and any next grant rising there are at least TURNAROUND+1 cycles with grant=0 (TURN plus the IDLE arbitration cycle).
- Reset asserted in any state returns to the reset values at that edge. This releases the bus immediately, with no turnaround.

## Timing
- Grant latency: req[i] high at edge E in IDLE gives grant/bus_oe high from E (visible the cycle after E).
- Release latency: req[g] low at edge E gives grant/bus_oe low after E.
- Gap: next grant is visible earliest TURNAROUND+1 cycles after release.
- Max ownership is MAX_HOLD cycles of bus_oe=1 per grant.
- Hold counter width: clog2(MAX_HOLD+1). Turn counter width: clog2(TURNAROUND+1). No wrap is possible.

## Test plan
- Reset values: assert reset 2 cycles while req=4'b1111. Required: grant=0, bus_oe=0, bus_d=0, busy=0. After release, the first grant goes to requester 0, one cycle later.
- Single owner (NREQ=4, WIDTH=4): req=4'b0010, wdata slice1=4'b1110 for 3 cycles. Required: grant=0010, bus_oe=1111, bus_d=1110 for 3 cycles. Then TURN 1 cycle, IDLE, busy timeline 1,1,1,1,0.
- Round-robin: req=4'b0101 held constant, MAX_HOLD=2. Required grant sequence: 0001(2 cyc), gap 2, 0100(2 cyc), gap 2, 0001. Never two consecutive grants to the same requester.
- Preemption: req=4'b0001 held 20 cycles, MAX_HOLD=8, TURNAROUND=1. Required pattern repeats: 8 cycles bus_oe=1111, 2 cycles bus_oe=0000.
- Contention guard: random req/wdata for 10k cycles. Required: popcount(grant)≤1 always, and bus_oe is 0 for ≥TURNAROUND+1 cycles at each owner change.
- Reset mid-DRIVE: reset in the 3rd DRIVE cycle. Required: grant=0 and bus_oe=0 at the next cycle, pointer back to 0.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus. Produces registered
// grant/enables and an enforced all-released turnaround between owners.
module tristate_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      bus_oe,
    output logic [WIDTH-1:0]      bus_d,
    output logic                  busy
);
    localparam int PW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [HW-1:0] hold;
    logic [TW-1:0] turn;

    logic          found;
    logic [PW-1:0] winner;
    logic [PW-1:0] cand;
    int            idx;

    // First set request at or after the pointer, wrapping past NREQ-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx  = (int'(ptr) + k) % NREQ;
            cand = idx[PW-1:0];
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            bus_oe <= '0;
            busy   <= 1'b0;
            hold   <= '0;
            turn   <= '0;
            ptr    <= '0;
            owner  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state  <= DRIVE;
                        owner  <= winner;
                        grant  <= NREQ'(1) << winner;
                        bus_oe <= '1;
                        busy   <= 1'b1;
                        hold   <= HW'(1);
                    end
                end
                DRIVE: begin
                    if (!req[owner] || hold == HW'(MAX_HOLD)) begin
                        state  <= TURN;
                        grant  <= '0;
                        bus_oe <= '0;
                        hold   <= '0;
                        turn   <= TW'(1);
                        ptr    <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                TURN: begin
                    // Requests are not looked at until the bus has been released long enough.
                    if (turn == TW'(TURNAROUND)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        turn  <= '0;
                    end else begin
                        turn <= turn + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // AND-OR mux; zero whenever no grant is held.
    always_comb begin
        bus_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus_d = bus_d | (wdata[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios with literal expectations
// plus a randomized run compared every cycle against an ownership-timeline model.
module tb_tristate_bus_arbiter;
    localparam int NREQ       = 4;
    localparam int WIDTH      = 4;
    localparam int MAX_HOLD   = 8;
    localparam int TURNAROUND = 1;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '1;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]       grant;
    logic [WIDTH-1:0]      bus_oe;
    logic [WIDTH-1:0]      bus_d;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    logic [NREQ-1:0] exp_q[$];

    tristate_bus_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .grant(grant), .bus_oe(bus_oe), .bus_d(bus_d), .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- ownership-timeline model ----------------
    int m_owner    = -1;
    int m_len      = 0;
    int m_gap      = 0;
    int m_ptr      = 0;
    bit m_valid    = 0;
    bit gap_exempt = 1;
    int zero_run   = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_owner    = -1;
            m_len      = 0;
            m_gap      = 0;
            m_ptr      = 0;
            m_valid    = 1;
            gap_exempt = 1;
        end else if (m_owner >= 0) begin
            if (!req[m_owner] || m_len == MAX_HOLD) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_gap   = TURNAROUND;
            end else begin
                m_len++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    m_len   = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [NREQ-1:0]  e_grant;
        logic [WIDTH-1:0] e_oe;
        logic [WIDTH-1:0] e_d;
        logic             e_busy;
        if (m_valid) begin
            e_grant = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
            e_oe    = (m_owner >= 0) ? '1 : '0;
            e_d     = (m_owner >= 0) ? wdata[m_owner*WIDTH +: WIDTH] : '0;
            e_busy  = (m_owner >= 0) || (m_gap > 0);
            chk("model_grant", 32'(grant), 32'(e_grant));
            chk("model_oe", 32'(bus_oe), 32'(e_oe));
            chk("model_d", 32'(bus_d), 32'(e_d));
            chk("model_busy", 32'(busy), 32'(e_busy));
            chk("onehot_grant", 32'($countones(grant) <= 1), 32'(1));
            chk("oe_iff_grant", 32'(bus_oe == '1), 32'(grant != '0));
            if (grant == '0) begin
                zero_run++;
            end else begin
                if (zero_run > 0 && !gap_exempt)
                    chk("turn_gap", 32'(zero_run >= TURNAROUND + 1), 32'(1));
                if (zero_run > 0) gap_exempt = 0;
                zero_run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset values with every requester asking.
        reset = 1'b1;
        req   = 4'b1111;
        wdata = 16'hABCD;
        tick();
        tick();
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_oe", 32'(bus_oe), 32'h0);
        chk("rst_d", 32'(bus_d), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_first_grant", 32'(grant), 32'h1);
        chk("rst_first_d", 32'(bus_d), 32'hD);

        // Single owner for three cycles, then TURN and IDLE.
        pulse_reset();
        req   = 4'b0010;
        wdata = 16'h55E5;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk("single_grant", 32'(grant), 32'b0010);
            chk("single_oe", 32'(bus_oe), 32'hF);
            chk("single_d", 32'(bus_d), 32'hE);
            chk("single_busy", 32'(busy), 32'h1);
        end
        req = 4'b0000;
        tick();
        @(negedge clk);
        chk("single_turn_grant", 32'(grant), 32'h0);
        chk("single_turn_busy", 32'(busy), 32'h1);
        tick();
        @(negedge clk);
        chk("single_idle_busy", 32'(busy), 32'h0);

        // Round-robin between requesters 0 and 2 with continuous demand.
        pulse_reset();
        req = 4'b0101;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < MAX_HOLD; c++) exp_q.push_back(4'b0001);
            for (int c = 0; c < 2; c++) exp_q.push_back(4'b0000);
            for (int c = 0; c < MAX_HOLD; c++) exp_q.push_back(4'b0100);
            for (int c = 0; c < 2; c++) exp_q.push_back(4'b0000);
        end
        while (exp_q.size() > 0) begin
            tick();
            @(negedge clk);
            chk("rr_grant", 32'(grant), 32'(exp_q.pop_front()));
        end

        // Lone requester is preempted every MAX_HOLD cycles.
        pulse_reset();
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            @(negedge clk);
            chk("preempt_oe", 32'(bus_oe), ((c % 10) < 8) ? 32'hF : 32'h0);
        end

        // Reset during the third DRIVE cycle releases at once and clears the pointer.
        pulse_reset();
        req = 4'b0110;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("middrive_grant", 32'(grant), 32'b0010);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("middrive_rst_grant", 32'(grant), 32'h0);
        chk("middrive_rst_oe", 32'(bus_oe), 32'h0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("middrive_ptr0", 32'(grant), 32'b0010);

        // Randomized contention: requests toggle occasionally, data every cycle.
        for (int c = 0; c < 10000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            wdata = NREQ*WIDTH'($urandom);
            reset = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0;
        tick();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
